axi_req_arbiter: RTL and testbench
==================================

# axi_req_arbiter

Sequences the AXI slave's request path onto the TL TX side. It picks between a pending memory-write TLP (header plus data beats) and a pending memory-read TLP (header only), gated by flow-control credit availability. It drives the slave's `axi_req_wr_grant` / `axi_req_rd_grant` pop strobes and streams the chosen TLP to the TX buffer with a valid/ready handshake.

## Interface
- `BEAT_DW`, default 32: DWs per data beat (`AXI_MAX_NUM_BYTES*8/32`).
- `DATA_W`, default 1024: data beat width in bits.
- `axi_clk`  in  1  the single clock; rising edge.
- `ARESTn`  in  1  asynchronous, active-low reset.
- `axi_wrreq_hdr_valid`  in  1  a write header is pending at the slave.
- `axi_wrreq_hdr`  in  tlp_header_t  write header.
- `axi_rdreq_hdr_valid`  in  1  a read header is pending at the slave.
- `axi_rdreq_hdr`  in  tlp_header_t  read header.
- `axi_req_data`  in  DATA_W  current write data beat from the slave.
- `fc_ph_ok`, `fc_pd_ok`, `fc_nph_ok`  in  1 each  posted-header, posted-data and non-posted-header credits sufficient.
- `axi_req_wr_grant`  out  1  slave pops the write header or data beat this cycle.
- `axi_req_rd_grant`  out  1  slave pops the read header this cycle.
- `tx_hdr_valid`  out  1  `tx_hdr` is valid.
- `tx_hdr`  out  tlp_header_t  selected header.
- `tx_data_valid`  out  1  `tx_data` is valid.
- `tx_data`  out  DATA_W  write data beat.
- `tx_last`  out  1  final data beat of the TLP.
- `tx_ready`  in  1  the TX buffer accepts the header or beat presented this cycle.

## Operation
- Eligibility:
  - `wr_elig = axi_wrreq_hdr_valid & fc_ph_ok & fc_pd_ok`
  - `rd_elig = axi_rdreq_hdr_valid & fc_nph_ok`
  - Evaluated only in IDLE. Credits are not re-checked mid-TLP.
- Selection: if only one side is eligible, that side wins. If both are eligible, round-robin on a `last_wr` flag: the side not served last wins. `last_wr` updates on each IDLE exit.
- FSM states: IDLE, WR_HDR, WR_DATA, RD_HDR.
  - IDLE→WR_HDR when the write is selected; IDLE→RD_HDR when the read is selected. IDLE holds otherwise.
  - WR_HDR: `tx_hdr_valid=1`, `tx_hdr=axi_wrreq_hdr`, `axi_req_wr_grant=tx_ready`. On `tx_ready`, load the beat counter and go to WR_DATA.
  - WR_DATA: `tx_data_valid=1`, `tx_data=axi_req_data`, `axi_req_wr_grant=tx_ready`. Each accepted beat decrements the counter. The beat accepted with counter==1 asserts `tx_last`, and the FSM returns to IDLE.
  - RD_HDR: `tx_hdr_valid=1`, `tx_hdr=axi_rdreq_hdr`, `axi_req_rd_grant=tx_ready`. On `tx_ready`, return to IDLE.
- Beat count: `ceil(Length/BEAT_DW)` on the 10-bit `Length` field. `Length==0` encodes 1024 DW and gives 32 beats. The counter is 6 bits wide.
- Grants are never high in IDLE, and never both high in the same cycle.
- If the slave's valid drops while in WR_HDR or RD_HDR (protocol violation), the block still completes the handshake. The slave is required to hold valid until granted.

## Timing
- Reset (async assert): state=IDLE, `last_wr=0` (first tie goes to write). All outputs are 0: grants, `tx_hdr_valid`, `tx_hdr`, `tx_data_valid`, `tx_data`, `tx_last`.
- Latency: a request eligible at rising edge N produces `tx_hdr_valid` in cycle N+1 (one registered decision cycle).
- Handshake: a transfer occurs on a cycle with valid & `tx_ready`. While `tx_ready=0`, valid, header and data stay stable and grants are 0.
- Minimum cost of a write with L beats: 1 (IDLE) + 1 (header) + L cycles. A read costs 2 cycles.
- Back-to-back: from the last beat or read-header accept there is exactly one IDLE cycle before the next header.
- Credits dropping after the IDLE decision do not abort the TLP.
- Reset mid-TLP abandons it immediately; the downstream side is reset by the same `ARESTn`.

## Structure
- The shared package (`axi_slave_package`) holds:
  - `tlp_header_t`
  - `arb_state_t` (enum of the four states)
  - `AXI_BEAT_DW` constant
- A single sub-module `rr_picker_2` is natural: two requests plus `last_wr` in, one-hot pick out, combinational.
- The FSM, beat counter and output muxing live in `axi_req_arbiter`.

## Test plan
- Write only, Length=64, all credits OK, `tx_ready=1`:
  - `tx_hdr_valid` at N+1, data beats at N+2 and N+3 with `tx_last` at N+3.
  - `axi_req_wr_grant` high in 3 cycles.
- Write and read both valid in the same cycle, from reset:
  - The write goes first (1 header + beats), then IDLE, then the read header.
  - On the next simultaneous pair, the read goes first.
- Read valid with `fc_nph_ok=0`, write valid with credits OK:
  - The write is served.
  - After `fc_nph_ok` rises, the read header appears 1 cycle later.
- Length=0 write:
  - Exactly 32 beats.
  - `tx_last` only on the 32nd.
  - The counter does not wrap.
- `tx_ready` toggled randomly during a 5-beat write:
  - Header and data stay stable while stalled.
  - Grant count = 6.
  - No grant while `tx_ready=0`.
- `ARESTn` pulsed low in the middle of WR_DATA:
  - All outputs go to 0 asynchronously.
  - After release, a pending read wins the tie (`last_wr=0` → write preferred only if the write is also valid).

Source files
------------

// File: rtl/axi_slave_package.sv
// axi_slave_package: shared TLP header type, arbiter state encoding and beat sizing helper
package axi_slave_package;
   localparam int unsigned AXI_BEAT_DW = 32;
   typedef struct packed {
      logic [2:0]  fmt;
      logic [4:0]  typ;
      logic [7:0]  tag;
      logic [63:0] addr;
      logic [9:0]  length;
   } tlp_header_t;
   typedef enum logic [1:0] {IDLE, WR_HDR, WR_DATA, RD_HDR} arb_state_t;
   // Length==0 means 1024 DW, which the leading bit of dw supplies directly
   function automatic logic [5:0] beat_count(input logic [9:0] len, input int unsigned bdw);
      logic [10:0] dw;
      dw = {len == 10'd0, len};
      return 6'((32'(dw) + bdw - 32'd1) / bdw);
   endfunction
endpackage

// File: rtl/rr_picker_2.sv
// rr_picker_2: two-way round-robin pick, favouring the side not served last
module rr_picker_2 (
   input  logic wr_req,
   input  logic rd_req,
   input  logic last_wr,
   output logic pick_wr,
   output logic pick_rd
);
   assign pick_wr = wr_req & (~rd_req | ~last_wr);
   assign pick_rd = rd_req & (~wr_req | last_wr);
endmodule

// File: rtl/axi_req_arbiter.sv
// axi_req_arbiter: credit-gated write/read TLP arbiter streaming header and beats to TX
module axi_req_arbiter
   import axi_slave_package::*;
#(
   parameter int unsigned BEAT_DW = AXI_BEAT_DW,
   parameter int unsigned DATA_W  = 1024
) (
   input  logic              axi_clk,
   input  logic              ARESTn,
   input  logic              axi_wrreq_hdr_valid,
   input  tlp_header_t       axi_wrreq_hdr,
   input  logic              axi_rdreq_hdr_valid,
   input  tlp_header_t       axi_rdreq_hdr,
   input  logic [DATA_W-1:0] axi_req_data,
   input  logic              fc_ph_ok,
   input  logic              fc_pd_ok,
   input  logic              fc_nph_ok,
   output logic              axi_req_wr_grant,
   output logic              axi_req_rd_grant,
   output logic              tx_hdr_valid,
   output tlp_header_t       tx_hdr,
   output logic              tx_data_valid,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_last,
   input  logic              tx_ready
);
   arb_state_t state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic       last_wr_q, last_wr_d;
   logic       wr_elig, rd_elig, pick_wr, pick_rd;

   assign wr_elig = axi_wrreq_hdr_valid & fc_ph_ok & fc_pd_ok;
   assign rd_elig = axi_rdreq_hdr_valid & fc_nph_ok;

   rr_picker_2 u_pick (
      .wr_req  (wr_elig),
      .rd_req  (rd_elig),
      .last_wr (last_wr_q),
      .pick_wr (pick_wr),
      .pick_rd (pick_rd)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_wr_d = last_wr_q;
      case (state_q)
         IDLE: begin
            state_d   = pick_wr ? WR_HDR : pick_rd ? RD_HDR : IDLE;
            last_wr_d = pick_wr ? 1'b1 : pick_rd ? 1'b0 : last_wr_q;
         end
         WR_HDR: begin
            state_d = tx_ready ? WR_DATA : WR_HDR;
            cnt_d   = tx_ready ? beat_count(axi_wrreq_hdr.length, BEAT_DW) : cnt_q;
         end
         WR_DATA: begin
            state_d = (tx_ready && cnt_q == 6'd1) ? IDLE : WR_DATA;
            cnt_d   = tx_ready ? cnt_q - 6'd1 : cnt_q;
         end
         RD_HDR: state_d = tx_ready ? IDLE : RD_HDR;
      endcase
   end

   always_ff @(posedge axi_clk or negedge ARESTn) begin
      if (!ARESTn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_wr_q <= last_wr_d;
      end
   end

   // Outputs decode the registered state, so an async reset clears them at once
   assign tx_hdr_valid     = (state_q == WR_HDR) | (state_q == RD_HDR);
   assign tx_hdr           = (state_q == WR_HDR) ? axi_wrreq_hdr : (state_q == RD_HDR) ? axi_rdreq_hdr : '0;
   assign tx_data_valid    = state_q == WR_DATA;
   assign tx_data          = tx_data_valid ? axi_req_data : '0;
   assign tx_last          = tx_data_valid & (cnt_q == 6'd1);
   assign axi_req_wr_grant = tx_ready & ((state_q == WR_HDR) | (state_q == WR_DATA));
   assign axi_req_rd_grant = tx_ready & (state_q == RD_HDR);
endmodule

// File: tb/tb_axi_req_arbiter.sv
// tb_axi_req_arbiter: directed tests with a transaction-level reference model checked every cycle
module tb_axi_req_arbiter;
   import axi_slave_package::*;
   localparam int DW = 1024;
   localparam int BDW = 32;

   logic          axi_clk = 1'b0;
   logic          ARESTn = 1'b0;
   logic          axi_wrreq_hdr_valid, axi_rdreq_hdr_valid;
   tlp_header_t   axi_wrreq_hdr, axi_rdreq_hdr, tx_hdr;
   logic [DW-1:0] axi_req_data, tx_data;
   logic          fc_ph_ok, fc_pd_ok, fc_nph_ok;
   logic          axi_req_wr_grant, axi_req_rd_grant;
   logic          tx_hdr_valid, tx_data_valid, tx_last, tx_ready;

   axi_req_arbiter dut (
      .axi_clk             (axi_clk),
      .ARESTn              (ARESTn),
      .axi_wrreq_hdr_valid (axi_wrreq_hdr_valid),
      .axi_wrreq_hdr       (axi_wrreq_hdr),
      .axi_rdreq_hdr_valid (axi_rdreq_hdr_valid),
      .axi_rdreq_hdr       (axi_rdreq_hdr),
      .axi_req_data        (axi_req_data),
      .fc_ph_ok            (fc_ph_ok),
      .fc_pd_ok            (fc_pd_ok),
      .fc_nph_ok           (fc_nph_ok),
      .axi_req_wr_grant    (axi_req_wr_grant),
      .axi_req_rd_grant    (axi_req_rd_grant),
      .tx_hdr_valid        (tx_hdr_valid),
      .tx_hdr              (tx_hdr),
      .tx_data_valid       (tx_data_valid),
      .tx_data             (tx_data),
      .tx_last             (tx_last),
      .tx_ready            (tx_ready)
   );

   always #5 axi_clk = ~axi_clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // slave side: pending headers waiting to be granted
   tlp_header_t wq[$];
   tlp_header_t rq[$];

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] f;
      for (int i = 0; i < DW / 32; i++) f[i*32 +: 32] = $urandom;
      return f;
   endfunction

   function automatic tlp_header_t mk_hdr(input logic [9:0] len);
      tlp_header_t h;
      h = '0;
      h.length = len;
      h.addr = {$urandom, $urandom};
      h.tag = 8'($urandom);
      h.fmt = 3'($urandom);
      return h;
   endfunction

   task automatic refresh();
      axi_wrreq_hdr_valid = wq.size() > 0;
      axi_wrreq_hdr       = (wq.size() > 0) ? wq[0] : '0;
      axi_rdreq_hdr_valid = rq.size() > 0;
      axi_rdreq_hdr       = (rq.size() > 0) ? rq[0] : '0;
   endtask

   // reference model: which TLP is in flight, whether its header has gone, beats left
   int m_kind = 0;
   bit m_hdr_done = 0;
   int m_left = 0;
   bit m_last_wr = 0;
   logic p_hv = 0, p_dv = 0, p_rdy = 0;
   tlp_header_t p_hdr;
   logic [DW-1:0] p_data;

   always @(negedge axi_clk) begin
      logic e_hv, e_dv, e_last, e_wg, e_rg, we, re;
      tlp_header_t e_hdr;
      logic [DW-1:0] e_data;
      int len;
      e_hv = 0; e_dv = 0; e_last = 0; e_wg = 0; e_rg = 0;
      e_hdr = '0; e_data = '0;
      if (ARESTn) begin
         if (m_kind == 1 && !m_hdr_done) begin
            e_hv = 1; e_hdr = axi_wrreq_hdr; e_wg = tx_ready;
         end else if (m_kind == 1) begin
            e_dv = 1; e_data = axi_req_data; e_last = (m_left == 1); e_wg = tx_ready;
         end else if (m_kind == 2) begin
            e_hv = 1; e_hdr = axi_rdreq_hdr; e_rg = tx_ready;
         end
      end
      chk("hdr_valid", 128'(tx_hdr_valid), 128'(e_hv));
      chk("hdr", 128'(tx_hdr), 128'(e_hdr));
      chk("data_valid", 128'(tx_data_valid), 128'(e_dv));
      chk("data_lo", tx_data[127:0], e_data[127:0]);
      chk("data_full_eq", 128'(tx_data == e_data), 128'(1));
      chk("last", 128'(tx_last), 128'(e_last));
      chk("wr_grant", 128'(axi_req_wr_grant), 128'(e_wg));
      chk("rd_grant", 128'(axi_req_rd_grant), 128'(e_rg));
      if (ARESTn && p_hv && !p_rdy) chk("stall_hdr", 128'(tx_hdr), 128'(p_hdr));
      if (ARESTn && p_dv && !p_rdy) chk("stall_data_eq", 128'(tx_data == p_data), 128'(1));
      p_hv = ARESTn & tx_hdr_valid; p_dv = ARESTn & tx_data_valid; p_rdy = tx_ready;
      p_hdr = tx_hdr; p_data = tx_data;
      if (!ARESTn) begin
         m_kind = 0; m_hdr_done = 0; m_left = 0; m_last_wr = 0;
      end else if (m_kind == 0) begin
         we = axi_wrreq_hdr_valid & fc_ph_ok & fc_pd_ok;
         re = axi_rdreq_hdr_valid & fc_nph_ok;
         if (we && (!re || !m_last_wr)) begin
            len = (axi_wrreq_hdr.length == 0) ? 1024 : int'(axi_wrreq_hdr.length);
            m_kind = 1; m_hdr_done = 0; m_left = (len + BDW - 1) / BDW; m_last_wr = 1;
         end else if (re) begin
            m_kind = 2; m_last_wr = 0;
         end
      end else if (tx_ready) begin
         if (m_kind == 2) m_kind = 0;
         else if (!m_hdr_done) m_hdr_done = 1;
         else begin
            m_left--;
            if (m_left == 0) m_kind = 0;
         end
      end
   end

   // per-cycle samples for the hand-computed literal expectations
   logic s_hv, s_dv, s_last, s_wg, s_rg, s_rdy;
   logic [15:0] hv_v, dv_v, last_v, wg_v, rg_v;
   int n_dv, n_last, n_wg, dv_at_last, n_stall_grant;

   task automatic clear_stats();
      hv_v = '0; dv_v = '0; last_v = '0; wg_v = '0; rg_v = '0;
      n_dv = 0; n_last = 0; n_wg = 0; dv_at_last = 0; n_stall_grant = 0;
   endtask

   task automatic cycle();
      @(negedge axi_clk);
      s_hv = tx_hdr_valid; s_dv = tx_data_valid; s_last = tx_last;
      s_wg = axi_req_wr_grant; s_rg = axi_req_rd_grant; s_rdy = tx_ready;
      hv_v = {hv_v[14:0], s_hv}; dv_v = {dv_v[14:0], s_dv}; last_v = {last_v[14:0], s_last};
      wg_v = {wg_v[14:0], s_wg}; rg_v = {rg_v[14:0], s_rg};
      n_dv += int'(s_dv); n_last += int'(s_last); n_wg += int'(s_wg);
      if (s_last) dv_at_last = n_dv;
      if ((s_wg || s_rg) && !s_rdy) n_stall_grant++;
      @(posedge axi_clk);
      #1;
      if (s_wg && s_hv) void'(wq.pop_front());
      if (s_wg) axi_req_data = rnd_data();
      if (s_rg) void'(rq.pop_front());
      refresh();
   endtask

   task automatic run(input int n);
      clear_stats();
      repeat (n) cycle();
   endtask

   initial begin
      bit done;
      tx_ready = 1; fc_ph_ok = 1; fc_pd_ok = 1; fc_nph_ok = 1;
      axi_req_data = rnd_data();
      refresh();
      #3;
      chk("rst_hv", 128'(tx_hdr_valid), 128'(0));
      chk("rst_dv", 128'(tx_data_valid), 128'(0));
      chk("rst_wg", 128'(axi_req_wr_grant), 128'(0));
      chk("rst_hdr", 128'(tx_hdr), 128'(0));
      @(posedge axi_clk);
      #1 ARESTn = 1;

      // tie from reset: write first, then queued read beats the second write
      wq.push_back(mk_hdr(10'd32)); rq.push_back(mk_hdr(10'd1)); wq.push_back(mk_hdr(10'd32));
      refresh();
      run(9);
      chk("tie_hv", 128'(hv_v), 128'(9'b010010100));
      chk("tie_wg", 128'(wg_v), 128'(9'b011000110));
      chk("tie_rg", 128'(rg_v), 128'(9'b000010000));

      // single write of 64 DW: two beats
      wq.push_back(mk_hdr(10'd64)); refresh();
      run(5);
      chk("w64_hv", 128'(hv_v), 128'(5'b01000));
      chk("w64_dv", 128'(dv_v), 128'(5'b00110));
      chk("w64_last", 128'(last_v), 128'(5'b00010));
      chk("w64_grants", 128'(n_wg), 128'(3));

      // read blocked by non-posted credit
      fc_nph_ok = 0;
      rq.push_back(mk_hdr(10'd4)); wq.push_back(mk_hdr(10'd32)); refresh();
      run(5);
      chk("nph_wg", 128'(wg_v), 128'(5'b01100));
      chk("nph_rg", 128'(rg_v), 128'(0));
      fc_nph_ok = 1;
      run(3);
      chk("nph_rise_rg", 128'(rg_v), 128'(3'b010));

      // Length==0: 32 beats, last only on the 32nd
      wq.push_back(mk_hdr(10'd0)); refresh();
      run(36);
      chk("l0_beats", 128'(n_dv), 128'(32));
      chk("l0_lasts", 128'(n_last), 128'(1));
      chk("l0_last_pos", 128'(dv_at_last), 128'(32));
      chk("l0_grants", 128'(n_wg), 128'(33));

      // five-beat write under random backpressure
      wq.push_back(mk_hdr(10'd160)); refresh();
      clear_stats();
      done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         tx_ready = 1'($urandom_range(0, 1));
         cycle();
         if (s_last && s_wg) done = 1;
      end
      chk("bp_done", 128'(done), 128'(1));
      chk("bp_grants", 128'(n_wg), 128'(6));
      chk("bp_stall_grants", 128'(n_stall_grant), 128'(0));
      tx_ready = 1;
      run(2);

      // reset in the middle of the data phase, then a lone read
      wq.push_back(mk_hdr(10'd160)); refresh();
      run(3);
      #2 ARESTn = 0;
      #1;
      chk("mid_rst_dv", 128'(tx_data_valid), 128'(0));
      chk("mid_rst_data", tx_data[127:0], 128'(0));
      chk("mid_rst_wg", 128'(axi_req_wr_grant), 128'(0));
      chk("mid_rst_hv", 128'(tx_hdr_valid), 128'(0));
      wq.delete(); rq.push_back(mk_hdr(10'd8)); refresh();
      @(posedge axi_clk);
      #1 ARESTn = 1;
      run(3);
      chk("post_rst_rg", 128'(rg_v), 128'(3'b010));
      chk("post_rst_hv", 128'(hv_v), 128'(3'b010));
      run(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
